slow_clock_monitor: RTL and testbench
=====================================

Name: slow_clock_monitor

Overview:
- Receive-side checker for divided slow clocks such as the 1 Hz and 500 Hz traffic-controller clocks.
- Synchronises one slow clock input into the clk domain and emits single-cycle edge ticks.
- Measures the period in clk cycles and flags out-of-range periods and stuck inputs.
- One instance per divided clock; traffic FSM and display scanner consume the ticks as clock enables.

Parameters:
CNT_W, 28, width of period counter and period output
EXP_PERIOD, 100000000, expected period of clk_in in clk cycles
TOL, 1000, allowed absolute deviation from EXP_PERIOD in clk cycles
TIMEOUT_CYC, 150000000, clk cycles without a rising edge before timeout is declared (must be < 2^CNT_W - 1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
clk_in  in  1  slow clock under monitor, asynchronous to clk
en  in  1  monitor enable
rise_tick  out  1  one-cycle pulse per synchronised rising edge of clk_in
fall_tick  out  1  one-cycle pulse per synchronised falling edge of clk_in
period  out  CNT_W  last measured period in clk cycles
period_valid  out  1  one-cycle pulse when period/in_range update
in_range  out  1  last period within EXP_PERIOD +/- TOL
timeout  out  1  no rising edge for TIMEOUT_CYC cycles
duty_ok  out  1  duty-cycle check result (see Optional Feature)

Behaviour:
- Reset state: all outputs 0 except duty_ok=1; synchroniser flops, edge-history flop and counters are 0; FSM in IDLE.
- Synchroniser: 2 flops (s1, s2) plus history flop s3. rise = s2 & ~s3; fall = ~s2 & s3.
- Edge ticks are registered. clk_in first sampled high at edge N gives rise_tick high during the cycle after edge N+2 (3-edge latency). fall_tick behaves the same way.
- Ticks are produced whenever rst=0, independent of en and FSM state.
- FSM states:
  - IDLE: counter held at 0. Go to ARM when en=1.
  - ARM: wait for the first rise. On rise: counter <= 1, go to RUN. No period_valid from ARM.
  - RUN: counter increments by 1 every cycle.
    - On rise: period <= counter; period_valid pulses for 1 cycle, aligned with rise_tick; in_range <= (|counter - EXP_PERIOD| <= TOL); timeout <= 0; counter <= 1.
    - If counter reaches TIMEOUT_CYC with no rise: timeout <= 1, go to ARM. period and in_range hold.
  - Any state with en=0: go to IDLE next cycle. period, in_range and timeout hold their values.
- Period semantics: period equals the number of clk cycles between consecutive rise_tick pulses.
- Arithmetic: unsigned compare, no wrap. The counter saturates at 2^CNT_W - 1 and never wraps.
- Simultaneous events:
  - rise in the same cycle the counter hits TIMEOUT_CYC: the rise wins, the measurement completes and timeout stays 0.
  - en falling in the same cycle as a rise: the measurement completes, then the FSM goes to IDLE.
- timeout is sticky. It is cleared only by a completed RUN measurement or by rst.
- Reset mid-measurement clears everything immediately. The first measurement after reset needs two rising edges.

Optional Feature:
- Macro: SLOW_CLOCK_MONITOR_DUTY_CHECK_EN.
- Defined:
  - Adds a high-time counter, cleared at rise and incremented while s2=1.
  - At fall: high_time is latched.
  - At each period_valid: duty_ok <= (|2*high_time - period| <= 2*TOL), using CNT_W+1-bit arithmetic.
  - A first period with no prior fall gives duty_ok=0.
- Undefined: no high-time logic; duty_ok is tied to 1.

Test Plan (CNT_W=8, EXP_PERIOD=20, TOL=2, TIMEOUT_CYC=64):
1. en=1, clk_in toggling 10 high/10 low clk cycles → first period_valid at 2nd rise_tick; period=20, in_range=1, timeout=0; rise_tick exactly 3 edges after the clk_in rise is sampled.
2. clk_in 12 high/12 low → period=24, in_range=0. Then 11/11 → period=22, in_range=1 (TOL boundary).
3. clk_in held low after a valid period → timeout=1 exactly 64 cycles after the last rise_tick, FSM in ARM, period=20 holds. Restarting toggling → timeout clears at the 2nd rise.
4. rst asserted mid-RUN (counter=7) → all outputs 0 and duty_ok=1 at once. After release, no period_valid until two rises.
5. en dropped mid-RUN → no period_valid while en=0, rise_tick/fall_tick still pulse. en reasserted → ARM, then the next full period is measured correctly.
6. With SLOW_CLOCK_MONITOR_DUTY_CHECK_EN: clk_in 10/10 → duty_ok=1; 14/6 → duty_ok=0, period=20, in_range=1. Macro undefined → duty_ok constantly 1.

Source files
------------

// File: rtl/slow_clock_monitor.sv
// Slow-clock receiver: synchronises clk_in, emits edge ticks, measures period, flags range/timeout.
// Optional duty-cycle check is enabled with `define SLOW_CLOCK_MONITOR_DUTY_CHECK_EN.
module slow_clock_monitor #(
  parameter int CNT_W       = 28,
  parameter int EXP_PERIOD  = 100000000,
  parameter int TOL         = 1000,
  parameter int TIMEOUT_CYC = 150000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             en,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             timeout,
  output logic             duty_ok
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W:0]   EXP_C     = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);

  state_t             state_q, state_d;
  logic               s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic               rise_tick_q, rise_tick_d, fall_tick_q, fall_tick_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               pv_q, pv_d, in_range_q, in_range_d, timeout_q, timeout_d;
  logic [CNT_W:0]     cnt_ext, dev;
  logic               rise, fall, meas;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;
  assign meas = (state_q == RUN) && rise;

  always_comb begin
    s1_d        = clk_in;
    s2_d        = s1_q;
    s3_d        = s2_q;
    rise_tick_d = rise;
    fall_tick_d = fall;
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    pv_d        = 1'b0;
    in_range_d  = in_range_q;
    timeout_d   = timeout_q;
    cnt_ext     = {1'b0, cnt_q};
    dev         = (cnt_ext >= EXP_C) ? (cnt_ext - EXP_C) : (EXP_C - cnt_ext);
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = ARM;
      end
      ARM: begin
        cnt_d = '0;
        if (!en) state_d = IDLE;
        else if (rise) begin
          cnt_d   = CNT_W'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (rise) begin
          // A rise completes the measurement even when en drops or the timeout hits this cycle
          period_d   = cnt_q;
          pv_d       = 1'b1;
          in_range_d = (dev <= TOL_C);
          timeout_d  = 1'b0;
          cnt_d      = CNT_W'(1);
          state_d    = en ? RUN : IDLE;
        end else if (!en) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q >= TIMEOUT_C) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ARM;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      pv_q        <= 1'b0;
      in_range_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      rise_tick_q <= rise_tick_d;
      fall_tick_q <= fall_tick_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      pv_q        <= pv_d;
      in_range_q  <= in_range_d;
      timeout_q   <= timeout_d;
    end
  end

  assign rise_tick    = rise_tick_q;
  assign fall_tick    = fall_tick_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign in_range     = in_range_q;
  assign timeout      = timeout_q;

`ifdef SLOW_CLOCK_MONITOR_DUTY_CHECK_EN
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d, high_time_q, high_time_d;
  logic             high_vld_q, high_vld_d, duty_ok_q, duty_ok_d;
  logic [CNT_W:0]   high2, ddev;

  always_comb begin
    high_cnt_d  = high_cnt_q;
    high_time_d = high_time_q;
    high_vld_d  = high_vld_q;
    duty_ok_d   = duty_ok_q;
    high2       = {high_time_q, 1'b0};
    ddev        = (high2 >= cnt_ext) ? (high2 - cnt_ext) : (cnt_ext - high2);
    // The rise cycle is itself a high cycle, so the count restarts at 1
    if (rise) high_cnt_d = CNT_W'(1);
    else if (s2_q && high_cnt_q != CNT_MAX) high_cnt_d = high_cnt_q + 1'b1;
    if (fall) begin
      high_time_d = high_cnt_q;
      high_vld_d  = 1'b1;
    end else if (rise) begin
      high_vld_d  = 1'b0;
    end
    if (meas) duty_ok_d = high_vld_q && (ddev <= {TOL_C[CNT_W-1:0], 1'b0});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_cnt_q  <= '0;
      high_time_q <= '0;
      high_vld_q  <= 1'b0;
      duty_ok_q   <= 1'b1;
    end else begin
      high_cnt_q  <= high_cnt_d;
      high_time_q <= high_time_d;
      high_vld_q  <= high_vld_d;
      duty_ok_q   <= duty_ok_d;
    end
  end

  assign duty_ok = duty_ok_q;
`else
  assign duty_ok = 1'b1;
`endif

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Directed bench for slow_clock_monitor with CNT_W=8, EXP_PERIOD=20, TOL=2, TIMEOUT_CYC=64.
module tb_slow_clock_monitor;
  logic       clk = 1'b0;
  logic       rst, clk_in, en;
  logic       rise_tick, fall_tick, period_valid, in_range, timeout, duty_ok;
  logic [7:0] period;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, rt_cnt = 0, ft_cnt = 0, pv_cnt = 0, rt_at_pv1 = -1;
  int last_rt_cyc = 0, to_cyc = -1, last_period = -1, last_inr = -1;
  logic prev_to = 1'b0;
  int base_pv, base_rt, base_ft;

  slow_clock_monitor #(.CNT_W(8), .EXP_PERIOD(20), .TOL(2), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .clk_in(clk_in), .en(en),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .period(period),
    .period_valid(period_valid), .in_range(in_range), .timeout(timeout), .duty_ok(duty_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive n periods of clk_in, hi/lo measured in clk rising edges.
  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      clk_in = 1'b1;
      repeat (hi) @(negedge clk);
      clk_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  // Event recorder, sampled 2ns after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (rise_tick) begin rt_cnt++; last_rt_cyc = cyc; end
    if (fall_tick) ft_cnt++;
    if (period_valid) begin
      pv_cnt++;
      if (pv_cnt == 1) rt_at_pv1 = rt_cnt;
      last_period = int'(period);
      last_inr    = int'(in_range);
      chk("pv_aligned_with_rise_tick", int'(rise_tick), 1);
    end
    if (timeout && !prev_to) to_cyc = cyc;
    prev_to = timeout;
  end

  initial begin
    rst = 1'b1; en = 1'b0; clk_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rise_tick", int'(rise_tick), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_pv", int'(period_valid), 0);
    chk("rst_in_range", int'(in_range), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_duty_ok", int'(duty_ok), 1);
    rst = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    chk("state_arm", int'(dut.state_q), 1);

    // 1: latency and nominal period
    clk_in = 1'b1;
    @(negedge clk); chk("lat_edge_n", int'(rise_tick), 0);
    @(negedge clk); chk("lat_edge_n1", int'(rise_tick), 0);
    @(negedge clk); chk("lat_edge_n2", int'(rise_tick), 1);
    repeat (7) @(negedge clk);
    clk_in = 1'b0;
    repeat (10) @(negedge clk);
    wave(10, 10, 3);
    chk("t1_pv_cnt", pv_cnt, 3);
    chk("t1_first_pv_at_rt", rt_at_pv1, 2);
    chk("t1_period", last_period, 20);
    chk("t1_in_range", last_inr, 1);
    chk("t1_timeout", int'(timeout), 0);

    // 2: out of range and TOL boundary
    wave(12, 12, 3);
    chk("t2_period24", last_period, 24);
    chk("t2_in_range24", last_inr, 0);
    wave(11, 11, 3);
    chk("t2_period22", last_period, 22);
    chk("t2_in_range22", last_inr, 1);

    // 3: timeout
    wave(10, 10, 2);
    repeat (80) @(negedge clk);
    chk("t3_timeout", int'(timeout), 1);
    chk("t3_timeout_delay", to_cyc - last_rt_cyc, 64);
    chk("t3_state_arm", int'(dut.state_q), 1);
    chk("t3_period_hold", int'(period), 20);
    base_pv = pv_cnt;
    wave(10, 10, 1);
    chk("t3_no_pv_first_rise", pv_cnt, base_pv);
    chk("t3_timeout_sticky", int'(timeout), 1);
    wave(10, 10, 1);
    chk("t3_timeout_cleared", int'(timeout), 0);
    chk("t3_pv_second_rise", pv_cnt, base_pv + 1);

    // 4: reset mid-RUN at counter 7
    clk_in = 1'b1;
    repeat (3) @(negedge clk);
    repeat (6) @(negedge clk);
    chk("t4_cnt7", int'(dut.cnt_q), 7);
    rst = 1'b1; clk_in = 1'b0;
    #1;
    chk("t4_period", int'(period), 0);
    chk("t4_in_range", int'(in_range), 0);
    chk("t4_timeout", int'(timeout), 0);
    chk("t4_pv", int'(period_valid), 0);
    chk("t4_duty_ok", int'(duty_ok), 1);
    @(negedge clk);
    rst = 1'b0;
    base_pv = pv_cnt;
    wave(10, 10, 1);
    chk("t4_no_pv_one_rise", pv_cnt, base_pv);
    wave(10, 10, 1);
    chk("t4_pv_two_rises", pv_cnt, base_pv + 1);
    chk("t4_period", last_period, 20);

    // 5: en dropped mid-RUN
    en = 1'b0;
    base_pv = pv_cnt; base_rt = rt_cnt; base_ft = ft_cnt;
    wave(10, 10, 2);
    chk("t5_no_pv", pv_cnt, base_pv);
    chk("t5_rise_ticks", rt_cnt - base_rt, 2);
    chk("t5_fall_ticks", ft_cnt - base_ft, 2);
    chk("t5_state_idle", int'(dut.state_q), 0);
    en = 1'b1;
    @(negedge clk);
    chk("t5_state_arm", int'(dut.state_q), 1);
    wave(11, 11, 2);
    chk("t5_pv_one", pv_cnt, base_pv + 1);
    chk("t5_period", last_period, 22);
    chk("t5_in_range", last_inr, 1);

    // 6: duty cycle
    wave(14, 6, 3);
    chk("t6_period", last_period, 20);
    chk("t6_in_range", last_inr, 1);
`ifdef SLOW_CLOCK_MONITOR_DUTY_CHECK_EN
    chk("t6_duty_14_6", int'(duty_ok), 0);
    wave(10, 10, 3);
    chk("t6_duty_10_10", int'(duty_ok), 1);
`else
    chk("t6_duty_tied", int'(duty_ok), 1);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
